// File: rtl/regfile_pkg.sv
// Shared types for the regfile_bus register block: bus FSM state encodings.
package regfile_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_ACK  = 2'd1;
    localparam logic [1:0] ENC_HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_ACK  = ENC_ACK,
        ST_HOLD = ENC_HOLD
    } state_e;

endpackage

// File: rtl/regfile_reg.sv
// One read/write register with a reset value. With REGFILE_SHADOW_EN defined, writes
// land in a shadow stage that is copied to the live value when commit_i is high.
module regfile_reg
    import regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
`ifdef REGFILE_SHADOW_EN
    input  logic                  commit_i,
`endif
    output logic [DATA_WIDTH-1:0] live_o,
    output logic [DATA_WIDTH-1:0] rdback_o
);

    logic [DATA_WIDTH-1:0] live_q, live_d;

`ifdef REGFILE_SHADOW_EN
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;

    // Commit copies the shadow as it was before any write landing on the same edge.
    always_comb begin
        shadow_d = we_i ? wdata_i : shadow_q;
        live_d   = commit_i ? shadow_q : live_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            shadow_q <= RESET_VAL;
            live_q   <= RESET_VAL;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    assign rdback_o = shadow_q;
`else
    always_comb begin
        live_d = we_i ? wdata_i : live_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            live_q <= RESET_VAL;
        end else begin
            live_q <= live_d;
        end
    end

    assign rdback_o = live_q;
`endif

    assign live_o = live_q;

endmodule

// File: rtl/regfile_bus.sv
// Bus-accessible register file with read-only status registers and one-cycle acknowledge.
// Optional macro REGFILE_SHADOW_EN adds shadow registers and the commit_i port.
module regfile_bus
    import regfile_pkg::*;
#(
    parameter int                              REG_NUM    = 16,
    parameter int                              ADDR_BITS  = 4,
    parameter int                              DATA_WIDTH = 8,
    parameter logic [REG_NUM-1:0]              RO_MASK    = '0,
    parameter logic [REG_NUM*DATA_WIDTH-1:0]   RESET_VALS = '0
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          req_i,
    input  logic                          write_i,
    input  logic [ADDR_BITS-1:0]          addr_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
`ifdef REGFILE_SHADOW_EN
    input  logic                          commit_i,
`endif
    input  logic [REG_NUM*DATA_WIDTH-1:0] regs_i,
    output logic                          ack_o,
    output logic                          err_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [REG_NUM*DATA_WIDTH-1:0] regs_o,
    output logic [REG_NUM-1:0]            wr_pulse_o,
    output state_e                        state_o
);

    localparam int DW = DATA_WIDTH;

    // Handshake: the master holds req_i until it sees ack_o; a request is accepted only
    // in IDLE, ack_o is high for exactly the following cycle, and the FSM waits in HOLD
    // until req_i drops so a held request is never accepted twice.
    state_e                state_q, state_d;
    logic                  accept, ack_live;
    logic                  in_range, sel_ro;
    logic [DW-1:0]         sel_rdata;
    logic [DW-1:0]         reg_rd [REG_NUM];
    logic                  wr_ok_q, wr_ok_d, err_q, err_d;
    logic [ADDR_BITS-1:0]  waddr_q, waddr_d;
    logic [DW-1:0]         wdata_q, wdata_d, data_q, data_d;
    logic                  unused_regs;

    always_comb begin
        in_range  = 1'b0;
        sel_ro    = 1'b0;
        sel_rdata = '0;
        for (int n = 0; n < REG_NUM; n++) begin
            if (addr_i == ADDR_BITS'(n)) begin
                in_range  = 1'b1;
                sel_ro    = RO_MASK[n];
                sel_rdata = RO_MASK[n] ? regs_i[n*DW +: DW] : reg_rd[n];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_i) state_d = ST_ACK;
            ST_ACK:  state_d = req_i ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (!req_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = (state_q == ST_IDLE) && req_i;

    // The write is held pending through the ACK cycle so a reset there can still drop it.
    always_comb begin
        wr_ok_d = wr_ok_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        if (accept) begin
            wr_ok_d = write_i && in_range && !sel_ro;
            err_d   = write_i ? !(in_range && !sel_ro) : !in_range;
            waddr_d = addr_i;
            wdata_d = data_i;
            if (!write_i) data_d = sel_rdata;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            wr_ok_q <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_ok_q <= wr_ok_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    assign ack_live    = (state_q == ST_ACK) && !reset_i;
    assign ack_o       = ack_live;
    assign err_o       = ack_live && err_q;
    assign data_o      = data_q;
    assign state_o     = state_q;
    assign unused_regs = ^regs_i;

    for (genvar n = 0; n < REG_NUM; n++) begin : g_reg
        assign wr_pulse_o[n] = ack_live && wr_ok_q && (waddr_q == ADDR_BITS'(n));
        if (RO_MASK[n]) begin : g_ro
            assign reg_rd[n]           = '0;
            assign regs_o[n*DW +: DW]  = regs_i[n*DW +: DW];
        end else begin : g_rw
            logic [DW-1:0] live;
            regfile_reg #(
                .DATA_WIDTH (DW),
                .RESET_VAL  (RESET_VALS[n*DW +: DW])
            ) u_reg (
                .clock_i  (clock_i),
                .reset_i  (reset_i),
                .we_i     (wr_pulse_o[n]),
                .wdata_i  (wdata_q),
`ifdef REGFILE_SHADOW_EN
                .commit_i (commit_i),
`endif
                .live_o   (live),
                .rdback_o (reg_rd[n])
            );
`ifdef REGFILE_SHADOW_EN
            assign regs_o[n*DW +: DW] = live;
`else
            assign regs_o[n*DW +: DW] = wr_pulse_o[n] ? wdata_q : live;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_bus.sv
// Directed bench for regfile_bus: a 4-register instance (reg3 read-only, reg2 resets
// to 8'h5A) and a 3-register instance sharing the same bus for out-of-range accesses.
`timescale 1ns/1ps
module tb_regfile_bus;
    import regfile_pkg::*;

`ifdef REGFILE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, req_i, write_i;
    logic [1:0]  addr_i;
    logic [7:0]  data_i;
    logic [31:0] regs_i;
`ifdef REGFILE_SHADOW_EN
    logic        commit_i;
`endif
    logic        ack_o, err_o;
    logic [7:0]  data_o;
    logic [31:0] regs_o;
    logic [3:0]  wr_pulse_o;
    state_e      state_o;
    logic        ack3, err3;
    logic [7:0]  data3;
    logic [23:0] regs3;
    logic [2:0]  pulse3;
    state_e      state3;

    regfile_bus #(
        .REG_NUM(4), .ADDR_BITS(2), .DATA_WIDTH(8),
        .RO_MASK(4'b1000), .RESET_VALS(32'h005A_0000)
    ) u_dut (
        .clock_i(clk), .reset_i(reset_i), .req_i(req_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i),
`ifdef REGFILE_SHADOW_EN
        .commit_i(commit_i),
`endif
        .regs_i(regs_i), .ack_o(ack_o), .err_o(err_o), .data_o(data_o),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .state_o(state_o)
    );

    regfile_bus #(
        .REG_NUM(3), .ADDR_BITS(2), .DATA_WIDTH(8),
        .RO_MASK(3'b000), .RESET_VALS(24'h0)
    ) u_dut3 (
        .clock_i(clk), .reset_i(reset_i), .req_i(req_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i),
`ifdef REGFILE_SHADOW_EN
        .commit_i(commit_i),
`endif
        .regs_i(regs_i[23:0]), .ack_o(ack3), .err_o(err3), .data_o(data3),
        .regs_o(regs3), .wr_pulse_o(pulse3), .state_o(state3)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          acks, ack_at, acks3;
    logic        t_err, t_err3;
    logic [7:0]  t_data, t_data3;
    logic [3:0]  t_pulse;
    logic [2:0]  t_pulse3;
    logic [31:0] t_regs;

    // Drive one request at a negedge, hold it for 'hold' cycles, and record what both
    // instances show while ack is high. Inputs are scrambled after accept when held.
    task automatic xfer(input logic wr, input logic [1:0] a, input logic [7:0] d, input int hold);
        acks = 0; ack_at = -1; acks3 = 0;
        t_err = 1'b0; t_err3 = 1'b0; t_data = '0; t_data3 = '0;
        t_pulse = '0; t_pulse3 = '0; t_regs = '0;
        req_i = 1'b1; write_i = wr; addr_i = a; data_i = d;
        for (int c = 0; c < hold + 3; c++) begin
            @(negedge clk);
            if (ack_o) begin
                if (acks == 0) ack_at = c;
                acks++;
                t_err = err_o; t_data = data_o; t_pulse = wr_pulse_o; t_regs = regs_o;
            end
            if (ack3) begin
                acks3++;
                t_err3 = err3; t_data3 = data3; t_pulse3 = pulse3;
            end
            if (c == 0 && hold > 1) begin
                addr_i = a + 2'd1; data_i = ~d; write_i = 1'b1;
            end
            if (c == hold - 1) begin
                req_i = 1'b0; write_i = 1'b0;
                addr_i = 2'($urandom_range(0, 3));
                data_i = 8'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset_i = 1'b1; req_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0; regs_i = '0;
`ifdef REGFILE_SHADOW_EN
        commit_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ack",   ack_o,      32'd0);
        check("rst_err",   err_o,      32'd0);
        check("rst_data",  data_o,     32'd0);
        check("rst_pulse", wr_pulse_o, 32'd0);
        check("rst_regs",  regs_o,     32'h005A_0000);
        check("rst_state", state_o,    32'(ENC_IDLE));
        reset_i = 1'b0;
        @(negedge clk);

        xfer(1'b0, 2'd2, 8'h00, 1);
        check("rd2_acks", acks,   32'd1);
        check("rd2_lat",  ack_at, 32'd0);
        check("rd2_data", t_data, 32'h5A);
        check("rd2_err",  t_err,  32'd0);

        xfer(1'b1, 2'd1, 8'd213, 3);
        check("wr1_acks",  acks,          32'd1);
        check("wr1_err",   t_err,         32'd0);
        check("wr1_pulse", t_pulse,       32'b0010);
        check("wr1_ackreg", t_regs[15:8], SHADOW ? 32'h00 : 32'd213);
        check("wr1_regs",  regs_o,        SHADOW ? 32'h005A_0000 : 32'h005A_D500);

        xfer(1'b0, 2'd1, 8'h00, 1);
        check("rd1_data", t_data, 32'd213);

        regs_i = 32'hC300_0000;
        #1;
        check("ro_mirror", regs_o[31:24], 32'hC3);

        xfer(1'b1, 2'd3, 8'h11, 1);
        check("wr3_err",   t_err,         32'd1);
        check("wr3_pulse", t_pulse,       32'd0);
        check("wr3_ro",    regs_o[31:24], 32'hC3);
        check("wr3_err3",  t_err3,        32'd1);
        check("wr3_pls3",  t_pulse3,      32'd0);

        xfer(1'b0, 2'd3, 8'h00, 1);
        check("rd3_data",  t_data,  32'hC3);
        check("rd3_err",   t_err,   32'd0);
        check("rd3_acks3", acks3,   32'd1);
        check("rd3_err3",  t_err3,  32'd1);
        check("rd3_data3", t_data3, 32'd0);

        xfer(1'b1, 2'd0, 8'h3C, 1);
        check("wr0_pulse", t_pulse,      32'b0001);
        check("wr0_hold",  t_data,       32'hC3);
        check("wr0_live",  regs_o[7:0],  SHADOW ? 32'h00 : 32'h3C);

        req_i = 1'b1; write_i = 1'b1; addr_i = 2'd0; data_i = 8'h77;
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("abort_ack",   ack_o,      32'd0);
        check("abort_pulse", wr_pulse_o, 32'd0);
        check("abort_err",   err_o,      32'd0);
        req_i = 1'b0; write_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        check("abort_regs",  regs_o[7:0], 32'h00);
        check("abort_state", state_o,     32'(ENC_IDLE));
        check("abort_data",  data_o,      32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack_o) cnt++;
        end
        check("abort_noack", cnt, 32'd0);

`ifdef REGFILE_SHADOW_EN
        xfer(1'b1, 2'd0, 8'hAA, 1);
        check("sh_pulse", t_pulse,     32'b0001);
        check("sh_live",  regs_o[7:0], 32'h00);
        xfer(1'b0, 2'd0, 8'h00, 1);
        check("sh_read",  t_data,      32'hAA);
        check("sh_pre",   regs_o[7:0], 32'h00);
        commit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0;
        check("sh_commit", regs_o[7:0], 32'hAA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
